fcc_mem_rd_arb: RTL and testbench

- Shares one memory read port among the FC unit's three read clients: pic (data), wgt (weights) and bias.
- Arbitrates round-robin and drives the request to memory.
- Routes returned beats, registered, back to the granted client only.
- Sits between the fcc datapath's read interfaces and the memory controller. One transaction is outstanding at a time.

---
 rtl/fcc_mem_rd_arb.sv | 144 ++++++++++++++
 tb/tb_fcc_mem_rd_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fcc_mem_rd_arb.sv
// Round-robin arbiter sharing one memory read port among the FC unit's pic, wgt and bias clients.
// One transaction is outstanding at a time; returned beats are registered and steered to the owner.
module fcc_mem_rd_arb #(
   parameter int ADDR_WIDTH        = 19,
   parameter int WORD_WIDTH        = 8,
   parameter int NUM_WORDS_IN_LINE = 32,
   parameter int SIZE_WIDTH        = 12,
   parameter int LV_WIDTH          = $clog2(NUM_WORDS_IN_LINE*WORD_WIDTH/8)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [2:0]                            cl_req,
   input  logic [3*ADDR_WIDTH-1:0]               cl_addr,
   input  logic [3*SIZE_WIDTH-1:0]               cl_size,
   output logic [2:0]                            cl_valid,
   output logic [2:0]                            cl_last,
   output logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0] cl_data,
   output logic [LV_WIDTH-1:0]                   cl_last_valid,
   output logic                                  mem_req,
   output logic [ADDR_WIDTH-1:0]                 mem_start_addr,
   output logic [SIZE_WIDTH-1:0]                 mem_size_bytes,
   input  logic                                  mem_valid,
   input  logic                                  mem_last,
   input  logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0] mem_data,
   input  logic [LV_WIDTH-1:0]                   mem_last_valid,
   output logic [1:0]                            gnt_id,
   output logic                                  busy,
   output logic                                  err_zero_size,
   output logic [1:0]                            state_dbg
);

   localparam int DW = NUM_WORDS_IN_LINE*WORD_WIDTH;

   // Handshake: cl_req is a level held until the client sees its cl_last; mem_req is a
   // level held until the first mem_valid; mem_valid has no back-pressure and every beat
   // accepted in ISSUE/XFER is forwarded one cycle later.
   typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              rr_last_q;
   logic [1:0]              id_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [SIZE_WIDTH-1:0]   size_q;
   logic                    err_q;
   logic [2:0]              cl_valid_q, cl_last_q;
   logic [DW-1:0]           cl_data_q;
   logic [LV_WIDTH-1:0]     cl_lv_q;

   logic [1:0]              c0, c1, c2, sel_id;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [SIZE_WIDTH-1:0]   sel_size;
   logic                    beat_ok;
   logic [2:0]              id_onehot;

   function automatic logic [1:0] rr_next(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   // Priority order starts just after the last owner.
   always_comb begin
      c0 = rr_next(rr_last_q);
      c1 = rr_next(c0);
      c2 = rr_next(c1);
      if (cl_req[c0])      sel_id = c0;
      else if (cl_req[c1]) sel_id = c1;
      else                 sel_id = c2;
   end

   always_comb begin
      sel_addr = '0;
      sel_size = '0;
      for (int i = 0; i < 3; i++) begin
         if (sel_id == 2'(i)) begin
            sel_addr = cl_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_size = cl_size[i*SIZE_WIDTH +: SIZE_WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|cl_req) state_d = (sel_size == '0) ? DONE : ISSUE;
         ISSUE:   if (mem_valid) state_d = mem_last ? DONE : XFER;
         XFER:    if (mem_valid && mem_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign beat_ok   = mem_valid && (state_q == ISSUE || state_q == XFER);
   assign id_onehot = (id_q == 2'd0) ? 3'b001 : (id_q == 2'd1) ? 3'b010 : 3'b100;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_last_q  <= 2'd2;
         id_q       <= 2'd0;
         addr_q     <= '0;
         size_q     <= '0;
         err_q      <= 1'b0;
         cl_valid_q <= 3'b000;
         cl_last_q  <= 3'b000;
         cl_data_q  <= '0;
         cl_lv_q    <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= 1'b0;
         if (state_q == IDLE && |cl_req) begin
            id_q   <= sel_id;
            addr_q <= sel_addr;
            size_q <= sel_size;
            // A zero-byte request is retired immediately and still consumes its turn.
            if (sel_size == '0) begin
               err_q     <= 1'b1;
               rr_last_q <= sel_id;
            end
         end
         if (state_q == DONE) rr_last_q <= id_q;
         cl_valid_q <= beat_ok ? id_onehot : 3'b000;
         cl_last_q  <= (beat_ok && mem_last) ? id_onehot : 3'b000;
         if (beat_ok) begin
            cl_data_q <= mem_data;
            cl_lv_q   <= mem_last ? mem_last_valid : '1;
         end
      end
   end

   assign mem_req        = (state_q == ISSUE);
   assign mem_start_addr = addr_q;
   assign mem_size_bytes = size_q;
   assign gnt_id         = (state_q == IDLE) ? 2'd3 : id_q;
   assign busy           = (state_q != IDLE);
   assign err_zero_size  = err_q;
   assign cl_valid       = cl_valid_q;
   assign cl_last        = cl_last_q;
   assign cl_data        = cl_data_q;
   assign cl_last_valid  = cl_lv_q;
   assign state_dbg      = state_q;

   a_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(cl_valid));
   a_last_in_valid: assert property (@(posedge clk) disable iff (!rst_n) (cl_last & ~cl_valid) == 3'b000);

endmodule

// File: tb/tb_fcc_mem_rd_arb.sv
// Directed-plus-random bench for fcc_mem_rd_arb with a round-robin grant model
// and a beat scoreboard; inputs change and outputs are sampled on the falling edge.
module tb_fcc_mem_rd_arb;

   localparam int AW  = 19;
   localparam int SW  = 12;
   localparam int LVW = 5;
   localparam int DW  = 256;
   localparam int EW  = 2 + 1 + LVW + DW;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [2:0]     cl_req;
   logic [3*AW-1:0] cl_addr;
   logic [3*SW-1:0] cl_size;
   logic [2:0]     cl_valid, cl_last;
   logic [DW-1:0]  cl_data;
   logic [LVW-1:0] cl_last_valid;
   logic           mem_req;
   logic [AW-1:0]  mem_start_addr;
   logic [SW-1:0]  mem_size_bytes;
   logic           mem_valid, mem_last;
   logic [DW-1:0]  mem_data;
   logic [LVW-1:0] mem_last_valid;
   logic [1:0]     gnt_id;
   logic           busy, err_zero_size;
   logic [1:0]     state_dbg;

   logic [AW-1:0]  a_tab [3];
   logic [SW-1:0]  s_tab [3];
   logic [EW-1:0]  exp_q [$];
   int             m_rr;
   int             n_checks = 0;
   int             n_err = 0;

   assign cl_addr = {a_tab[2], a_tab[1], a_tab[0]};
   assign cl_size = {s_tab[2], s_tab[1], s_tab[0]};

   fcc_mem_rd_arb dut (
      .clk(clk), .rst_n(rst_n), .cl_req(cl_req), .cl_addr(cl_addr), .cl_size(cl_size),
      .cl_valid(cl_valid), .cl_last(cl_last), .cl_data(cl_data), .cl_last_valid(cl_last_valid),
      .mem_req(mem_req), .mem_start_addr(mem_start_addr), .mem_size_bytes(mem_size_bytes),
      .mem_valid(mem_valid), .mem_last(mem_last), .mem_data(mem_data),
      .mem_last_valid(mem_last_valid), .gnt_id(gnt_id), .busy(busy),
      .err_zero_size(err_zero_size), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Grant rule: first requester in order last+1, last+2, last+3 (mod 3).
   function automatic int pick(input logic [2:0] req, input int rr);
      for (int k = 1; k <= 3; k++) begin
         if (req[(rr + k) % 3]) return (rr + k) % 3;
      end
      return -1;
   endfunction

   function automatic logic [2:0] onehot(input int id);
      logic [2:0] v;
      v = 3'b000;
      v[id] = 1'b1;
      return v;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, DW'(cl_valid), DW'(0));
      chk({tag, "_last"}, DW'(cl_last), DW'(0));
      chk({tag, "_data"}, cl_data, DW'(0));
      chk({tag, "_lv"}, DW'(cl_last_valid), DW'(0));
      chk({tag, "_mreq"}, DW'(mem_req), DW'(0));
      chk({tag, "_addr"}, DW'(mem_start_addr), DW'(0));
      chk({tag, "_size"}, DW'(mem_size_bytes), DW'(0));
      chk({tag, "_gnt"}, DW'(gnt_id), DW'(3));
      chk({tag, "_busy"}, DW'(busy), DW'(0));
      chk({tag, "_err"}, DW'(err_zero_size), DW'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_rr = 2;
   endtask

   // Caller sets cl_req on an IDLE falling edge; returns on the next IDLE falling edge.
   // abort_after >= 0 asserts reset once that many beats have been delivered.
   task automatic run_txn(input int nbeats, input logic [2:0] mid_req, input int abort_after);
      int id;
      logic [EW-1:0]  e;
      logic [DW-1:0]  d, last_d;
      logic [LVW-1:0] lv, lvx;
      logic           lst;
      id = pick(cl_req, m_rr);
      @(negedge clk);
      chk("issue_req", DW'(mem_req), DW'(1));
      chk("issue_gnt", DW'(gnt_id), DW'(id));
      chk("issue_addr", DW'(mem_start_addr), DW'(a_tab[id]));
      chk("issue_size", DW'(mem_size_bytes), DW'(s_tab[id]));
      chk("issue_busy", DW'(busy), DW'(1));
      chk("issue_err", DW'(err_zero_size), DW'(0));
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         chk("issue_hold_req", DW'(mem_req), DW'(1));
         chk("issue_hold_addr", DW'(mem_start_addr), DW'(a_tab[id]));
      end
      for (int b = 0; b < nbeats; b++) begin
         if (b == abort_after) begin
            rst_n = 1'b0;
            mem_valid = 1'b0;
            #1;
            chk_reset_outputs("abort");
            exp_q.delete();
            m_rr = 2;
            return;
         end
         d   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         lv  = LVW'($urandom_range(0, 31));
         lst = (b == nbeats - 1);
         lvx = lst ? lv : '1;
         mem_valid = 1'b1; mem_last = lst; mem_data = d; mem_last_valid = lv;
         exp_q.push_back({2'(id), lst, lvx, d});
         @(negedge clk);
         mem_valid = 1'b0; mem_last = 1'b0;
         mem_data = {8{$urandom}}; mem_last_valid = LVW'($urandom);
         e = exp_q.pop_front();
         chk("beat_valid", DW'(cl_valid), DW'(onehot(int'(e[EW-1:EW-2]))));
         chk("beat_last", DW'(cl_last), e[DW+LVW] ? DW'(onehot(int'(e[EW-1:EW-2]))) : DW'(0));
         chk("beat_data", cl_data, e[DW-1:0]);
         chk("beat_lv", DW'(cl_last_valid), DW'(e[DW+LVW-1:DW]));
         chk("beat_mreq_low", DW'(mem_req), DW'(0));
         chk("beat_gnt", DW'(gnt_id), DW'(id));
         last_d = d;
         if (b == 0) cl_req = cl_req | mid_req;
         if (!lst && $urandom_range(0, 1) == 1) begin
            @(negedge clk);
            chk("gap_valid", DW'(cl_valid), DW'(0));
            chk("gap_hold", cl_data, last_d);
         end
      end
      chk("done_busy", DW'(busy), DW'(1));
      @(negedge clk);
      chk("idle_gnt", DW'(gnt_id), DW'(3));
      chk("idle_busy", DW'(busy), DW'(0));
      chk("idle_valid", DW'(cl_valid), DW'(0));
      m_rr = id;
   endtask

   initial begin
      rst_n = 1'b0; cl_req = 3'b000;
      mem_valid = 1'b0; mem_last = 1'b0; mem_data = '0; mem_last_valid = '0;
      for (int i = 0; i < 3; i++) begin
         a_tab[i] = AW'($urandom);
         s_tab[i] = SW'($urandom_range(1, 4095));
      end
      m_rr = 2;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // single pic beat
      a_tab[0] = 19'h100; s_tab[0] = 12'd32;
      cl_req = 3'b001;
      run_txn(1, 3'b000, -1);
      cl_req = 3'b000;

      // all three requesting from a fresh reset: pic, wgt, bias, pic
      do_reset();
      for (int i = 0; i < 3; i++) begin
         s_tab[i] = 12'd128;
         a_tab[i] = AW'($urandom);
      end
      cl_req = 3'b111;
      repeat (4) run_txn(4, 3'b000, -1);
      cl_req = 3'b000;

      // pic arrives during a bias transfer and waits for it
      cl_req = 3'b100;
      run_txn(3, 3'b001, -1);
      cl_req = 3'b001;
      run_txn(2, 3'b000, -1);
      cl_req = 3'b000;

      // zero-size wgt request is dropped, then bias wins
      s_tab[1] = 12'd0;
      cl_req = 3'b010;
      @(negedge clk);
      chk("zero_err", DW'(err_zero_size), DW'(1));
      chk("zero_mreq", DW'(mem_req), DW'(0));
      chk("zero_gnt", DW'(gnt_id), DW'(1));
      cl_req = 3'b000;
      @(negedge clk);
      chk("zero_err_pulse", DW'(err_zero_size), DW'(0));
      chk("zero_mreq_after", DW'(mem_req), DW'(0));
      chk("zero_gnt_idle", DW'(gnt_id), DW'(3));
      m_rr = 1;
      s_tab[1] = 12'd64;
      cl_req = 3'b111;
      run_txn(2, 3'b000, -1);
      cl_req = 3'b000;

      // reset in the middle of a pic transfer, then a fresh request
      cl_req = 3'b001;
      run_txn(4, 3'b000, 2);
      cl_req = 3'b000;
      repeat (2) @(negedge clk);
      chk("abort_hold_mreq", DW'(mem_req), DW'(0));
      cl_req = 3'b001;
      rst_n = 1'b1;
      run_txn(1, 3'b000, -1);
      cl_req = 3'b000;

      // stray memory beats while idle
      for (int i = 0; i < 4; i++) begin
         mem_valid = 1'b1; mem_last = 1'($urandom);
         mem_data = {8{$urandom}};
         @(negedge clk);
         chk("idle_beat_valid", DW'(cl_valid), DW'(0));
         chk("idle_beat_last", DW'(cl_last), DW'(0));
         chk("idle_beat_busy", DW'(busy), DW'(0));
         chk("idle_beat_gnt", DW'(gnt_id), DW'(3));
      end
      mem_valid = 1'b0; mem_last = 1'b0;
      @(negedge clk);

      // random request mixes
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < 3; i++) begin
            a_tab[i] = AW'($urandom);
            s_tab[i] = SW'($urandom_range(1, 4095));
         end
         cl_req = 3'($urandom_range(1, 7));
         run_txn($urandom_range(1, 4), 3'b000, -1);
      end
      cl_req = 3'b000;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
